// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared state encoding and iteration-count helpers for the iterative root unit.
package sqrt_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic int iter_cnt(input int width, input int fbits);
    return (width + fbits) / 2;
  endfunction
  function automatic int ncyc(input int iter, input int bpc);
    return (iter + bpc - 1) / bpc;
  endfunction
endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one restoring square-root digit step (combinational).
module sqrt_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_ac,
  input  logic [WIDTH-1:0] i_q,
  input  logic [1:0]       i_bits,
  output logic [WIDTH+1:0] o_ac,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH+3:0] w_sh;
  logic [WIDTH+4:0] w_test;
  logic [WIDTH+4:0] w_sel;
  assign w_sh   = {i_ac, i_bits};
  assign w_test = {1'b0, w_sh} - (WIDTH+5)'({i_q, 2'b01});
  assign w_sel  = w_test[WIDTH+4] ? {1'b0, w_sh} : w_test;
  assign o_ac   = (WIDTH+2)'(w_sel);
  assign o_q    = WIDTH'({i_q, ~w_test[WIDTH+4]});
endmodule

// File: rtl/sqrt_iter_hs.sv
// sqrt_iter_hs: valid/ready restoring square root, 1 or 2 root bits per clock,
// optional round-to-nearest and a tag carried alongside the operand.
module sqrt_iter_hs
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FBITS = 0,
  parameter int BPC   = 1,
  parameter int ROUND = 0,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rad,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_root,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_rnd_up,
  output logic [TAG_W-1:0] out_tag
);
  localparam int ITER = iter_cnt(WIDTH, FBITS);
  localparam int NCYC = ncyc(ITER, BPC);
  localparam int CW   = $clog2(NCYC + 1);
  localparam int XP   = 2 * NCYC * BPC;
  localparam bit ODD  = (BPC == 2) && (ITER % 2 == 1);

  if (((WIDTH + FBITS) % 2 != 0) || (FBITS > WIDTH - 2) || (BPC != 1 && BPC != 2)) begin : g_bad_param
    $error("sqrt_iter_hs: illegal WIDTH/FBITS/BPC combination");
  end

  state_e           r_state, w_nstate;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH+1:0] r_ac;
  logic [XP-1:0]    r_x;
  logic [WIDTH-1:0] r_q;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_root, r_rem;
  logic             r_rnd;
  logic [TAG_W-1:0] r_otag;

  logic [WIDTH+1:0] w_ac [BPC+1];
  logic [WIDTH-1:0] w_q  [BPC+1];
  logic             w_acc, w_last;
  logic [WIDTH+1:0] w_acf;
  logic [WIDTH-1:0] w_qf, w_rem;
  logic             w_up;

  assign w_ac[0] = r_ac;
  assign w_q[0]  = r_q;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    sqrt_step #(.WIDTH(WIDTH)) u_step (
      .i_ac  (w_ac[g]),
      .i_q   (w_q[g]),
      .i_bits(r_x[XP-1-2*g -: 2]),
      .o_ac  (w_ac[g+1]),
      .o_q   (w_q[g+1])
    );
  end

  assign w_last = r_cnt == CW'(NCYC - 1);
  // An odd step count leaves the second step unused on the final cycle.
  assign w_acf  = (ODD && w_last) ? w_ac[1] : w_ac[BPC];
  assign w_qf   = (ODD && w_last) ? w_q[1]  : w_q[BPC];
  assign w_rem  = WIDTH'(w_acf);
  assign w_up   = (ROUND != 0) && (w_rem > w_qf);

  assign in_ready = rst_n & ~clear & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_acc    = in_valid & in_ready;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    w_nstate = w_acc ? CALC : IDLE;
      CALC:    w_nstate = w_last ? DONE : CALC;
      DONE:    w_nstate = out_ready ? (w_acc ? CALC : IDLE) : DONE;
      default: w_nstate = IDLE;
    endcase
    if (clear) w_nstate = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ac    <= '0;
      r_x     <= '0;
      r_q     <= '0;
      r_tag   <= '0;
      r_root  <= '0;
      r_rem   <= '0;
      r_rnd   <= 1'b0;
      r_otag  <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_acc) begin
        r_ac  <= '0;
        r_x   <= XP'(in_rad) << (XP - WIDTH);
        r_q   <= '0;
        r_tag <= in_tag;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_ac  <= w_ac[BPC];
        r_q   <= w_q[BPC];
        r_x   <= r_x << (2 * BPC);
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == CALC && w_last && !clear) begin
        r_root <= w_qf + WIDTH'(w_up);
        r_rem  <= w_rem;
        r_rnd  <= w_up;
        r_otag <= r_tag;
      end
    end
  end

  assign out_valid  = r_state == DONE;
  assign out_root   = r_root;
  assign out_rem    = r_rem;
  assign out_rnd_up = r_rnd;
  assign out_tag    = r_otag;
endmodule

// File: tb/tb_sqrt_iter_hs.sv
// tb_sqrt_iter_hs: directed vectors, handshake corner cases and a randomised
// exhaustive sweep across six parameterisations sharing one stimulus bus.
module tb_sqrt_iter_hs;
  localparam int N = 6;
  localparam int PW[N] = '{8, 8, 8, 8, 16, 10};
  localparam int PF[N] = '{0, 0, 0, 0, 4, 0};
  localparam int PB[N] = '{1, 1, 2, 2, 2, 2};
  localparam int PR[N] = '{0, 1, 0, 1, 0, 0};

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_rad = '0;
  logic [3:0]  in_tag = '0;
  logic [2:0]  sel = '0;
  logic [15:0] o_root [N];
  logic [15:0] o_rem  [N];
  logic        o_ir [N], o_ov [N], o_rnd [N];
  logic [3:0]  o_tag [N];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = PW[g];
    logic [W-1:0] root, rem;
    sqrt_iter_hs #(.WIDTH(W), .FBITS(PF[g]), .BPC(PB[g]), .ROUND(PR[g]), .TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid && sel == 3'(g)),
      .in_ready  (o_ir[g]),
      .in_rad    (in_rad[W-1:0]),
      .in_tag    (in_tag),
      .out_valid (o_ov[g]),
      .out_ready (sel == 3'(g) ? out_ready : 1'b1),
      .out_root  (root),
      .out_rem   (rem),
      .out_rnd_up(o_rnd[g]),
      .out_tag   (o_tag[g])
    );
    assign o_root[g] = 16'(root);
    assign o_rem[g]  = 16'(rem);
  end

  logic [15:0] c_root, c_rem;
  logic        c_ir, c_ov, c_rnd;
  logic [3:0]  c_tag;
  assign c_root = o_root[sel];
  assign c_rem  = o_rem[sel];
  assign c_ir   = o_ir[sel];
  assign c_ov   = o_ov[sel];
  assign c_rnd  = o_rnd[sel];
  assign c_tag  = o_tag[sel];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic accept(input int rad, input int tag);
    int k = 0;
    @(negedge clk);
    while (!c_ir && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("accept_timeout", 0, 1);
    in_valid = 1'b1; in_rad = 16'(rad); in_tag = 4'(tag);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!c_ov && lat < 50) begin @(posedge clk); #1 lat++; end
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic do_op(input int s, input int rad, input int tag,
                       output int root, output int rem, output int rnd, output int tg, output int lat);
    sel = 3'(s); out_ready = 1'b0;
    accept(rad, tag);
    wait_valid(lat);
    root = int'(c_root); rem = int'(c_rem); rnd = int'(c_rnd); tg = int'(c_tag);
    drain();
  endtask

  typedef struct {int s; int rad; int root; int rem; int rnd; int lat;} vec_t;
  vec_t v[$];

  initial begin
    int root, rem, rnd, tg, lat, seen;
    v.push_back('{0, 0, 0, 0, 0, 4});
    v.push_back('{0, 255, 15, 30, 0, 4});
    v.push_back('{0, 64, 8, 0, 0, 4});
    v.push_back('{0, 2, 1, 1, 0, 4});
    v.push_back('{1, 56, 7, 7, 0, 4});
    v.push_back('{1, 57, 8, 8, 1, 4});
    v.push_back('{1, 255, 16, 30, 1, 4});
    v.push_back('{2, 200, 14, 4, 0, 2});
    v.push_back('{3, 210, 14, 14, 0, 2});
    v.push_back('{3, 211, 15, 15, 1, 2});
    v.push_back('{4, 36, 24, 0, 0, 5});
    v.push_back('{4, 65535, 1023, 2031, 0, 5});
    v.push_back('{5, 1000, 31, 39, 0, 3});
    v.push_back('{5, 1023, 31, 62, 0, 3});

    #1;
    chk("rst_in_ready", int'(c_ir), 0);
    chk("rst_out_valid", int'(c_ov), 0);
    chk("rst_root", int'(c_root), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rst_release_in_ready", int'(c_ir), 1);

    foreach (v[i]) begin
      do_op(v[i].s, v[i].rad, i % 16, root, rem, rnd, tg, lat);
      chk($sformatf("vec%0d_root", i), root, v[i].root);
      chk($sformatf("vec%0d_rem", i), rem, v[i].rem);
      chk($sformatf("vec%0d_rnd", i), rnd, v[i].rnd);
      chk($sformatf("vec%0d_tag", i), tg, i % 16);
      chk($sformatf("vec%0d_lat", i), lat, v[i].lat);
    end

    // Backpressure, then accept on the same edge the held result drains.
    sel = 3'd0; out_ready = 1'b0;
    accept(100, 3);
    wait_valid(lat);
    chk("bp_lat", lat, 4);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", int'(c_ov), 1);
      chk("bp_root", int'(c_root), 10);
      chk("bp_rem", int'(c_rem), 0);
      chk("bp_tag", int'(c_tag), 3);
      chk("bp_in_ready", int'(c_ir), 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_rad = 16'd81; in_tag = 4'd5;
    #1 chk("b2b_in_ready", int'(c_ir), 1);
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_valid_dropped", int'(c_ov), 0);
    wait_valid(lat);
    chk("b2b_lat", lat, 4);
    chk("b2b_root", int'(c_root), 9);
    chk("b2b_tag", int'(c_tag), 5);
    drain();

    // clear mid-CALC
    accept(200, 1);
    @(posedge clk);
    @(negedge clk); clear = 1'b1;
    #1 chk("clr_in_ready", int'(c_ir), 0);
    @(posedge clk); #1 clear = 1'b0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1 seen |= int'(c_ov); end
    chk("clr_no_valid", seen, 0);
    chk("clr_idle_ready", int'(c_ir), 1);
    do_op(0, 49, 2, root, rem, rnd, tg, lat);
    chk("clr_next_root", root, 7);
    chk("clr_next_lat", lat, 4);

    // reset mid-CALC
    accept(200, 4);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("arst_in_ready", int'(c_ir), 0);
    chk("arst_root", int'(c_root), 0);
    chk("arst_tag", int'(c_tag), 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1 seen |= int'(c_ov); end
    chk("arst_no_valid", seen, 0);
    do_op(0, 144, 6, root, rem, rnd, tg, lat);
    chk("arst_next_root", root, 12);
    chk("arst_next_rem", rem, 0);

    // clear while a result is pending
    accept(25, 7);
    wait_valid(lat);
    chk("clrd_valid", int'(c_ov), 1);
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("clrd_dropped", int'(c_ov), 0);
    do_op(0, 16, 8, root, rem, rnd, tg, lat);
    chk("clrd_next_root", root, 4);
    chk("clrd_next_tag", tg, 8);

    // Exhaustive sweep with random handshakes
    for (int s = 0; s < 4; s++) begin
      int nxt = 0, done = 0, cyc = 0;
      int qr[$];
      logic acc, cons;
      sel = 3'(s);
      while (done < 256 && cyc < 20000) begin
        @(negedge clk);
        in_valid  = (nxt < 256) && ($urandom_range(0, 3) != 0);
        in_rad    = 16'(nxt);
        in_tag    = 4'(nxt ^ (nxt >> 4));
        out_ready = 1'($urandom_range(0, 1));
        #1;
        acc  = in_valid & c_ir;
        cons = c_ov & out_ready;
        if (cons) begin
          if (qr.size() == 0) chk("sweep_spurious", 1, 0);
          else begin
            int r, f, rm, up, fr;
            r = qr.pop_front();
            f = 0;
            while ((f + 1) * (f + 1) <= r) f++;
            rm = r - f * f;
            up = (PR[s] != 0 && rm > f) ? 1 : 0;
            fr = int'(c_root) - int'(c_rnd);
            chk($sformatf("sweep%0d_root_%0d", s, r), int'(c_root), f + up);
            chk($sformatf("sweep%0d_rem_%0d", s, r), int'(c_rem), rm);
            chk($sformatf("sweep%0d_rnd_%0d", s, r), int'(c_rnd), up);
            chk($sformatf("sweep%0d_tag_%0d", s, r), int'(c_tag), (r ^ (r >> 4)) & 15);
            chk($sformatf("sweep%0d_ident_%0d", s, r), fr * fr + int'(c_rem), r);
            chk($sformatf("sweep%0d_rembound_%0d", s, r), int'(int'(c_rem) <= 2 * fr), 1);
          end
          done++;
        end
        if (acc) begin qr.push_back(nxt); nxt++; end
        @(posedge clk); cyc++;
      end
      chk($sformatf("sweep%0d_count", s), done, 256);
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
